gray_rd_arbiter: RTL and testbench

- Shares the single gray-image read port (gray_req/gray_ready/gray_data) between two LBP engines, e.g. one engine per half of the 128x128 image.
- Grants are round-robin with one outstanding access at a time.
- Each engine sees a private request/valid read interface.
- Also merges the two engines' completion flags into one system-level finish pulse.

---
 rtl/gray_rd_arbiter.sv | 156 +++++++++++++++
 tb/tb_gray_rd_arbiter.sv | 254 +++++++++++++++++++++++++
 2 files changed

// File: rtl/gray_rd_arbiter.sv
// Round-robin arbiter sharing one gray-image read port between two LBP engines,
// plus a merge of both engines' completion flags into a single finish pulse.
module gray_rd_arbiter #(
    parameter int unsigned AW = 14,
    parameter int unsigned DW = 8
) (
    input  logic          clk,
    input  logic          reset,

    input  logic          c0_req,
    input  logic [AW-1:0] c0_addr,
    output logic          c0_valid,
    output logic [DW-1:0] c0_rdata,
    input  logic          c0_done,

    input  logic          c1_req,
    input  logic [AW-1:0] c1_addr,
    output logic          c1_valid,
    output logic [DW-1:0] c1_rdata,
    input  logic          c1_done,

    output logic [AW-1:0] gray_addr,
    output logic          gray_req,
    input  logic          gray_ready,
    input  logic [DW-1:0] gray_data,

    output logic          finish
);

    typedef enum logic [1:0] {
        StIdle,
        StIssue,
        StCapt,
        StResp
    } state_e;

    state_e        r_state, w_state_next;
    logic          r_grant, w_grant_next;
    logic          r_last_grant, w_last_grant_next;
    logic          r_gray_req, w_gray_req_next;
    logic [AW-1:0] r_gray_addr, w_gray_addr_next;
    logic          r_c0_valid, w_c0_valid_next;
    logic [DW-1:0] r_c0_rdata, w_c0_rdata_next;
    logic          r_c1_valid, w_c1_valid_next;
    logic [DW-1:0] r_c1_rdata, w_c1_rdata_next;

    logic          r_d0, r_d1, r_finish;
    logic          w_any_req, w_pick, w_both_done;

    assign w_any_req = c0_req | c1_req;
    // On a tie the client that did not win last time is picked.
    assign w_pick    = (c0_req & c1_req) ? ~r_last_grant : c1_req;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= StIdle;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next      = r_state;
        w_grant_next      = r_grant;
        w_last_grant_next = r_last_grant;
        w_gray_req_next   = r_gray_req;
        w_gray_addr_next  = r_gray_addr;
        w_c0_valid_next   = r_c0_valid;
        w_c0_rdata_next   = r_c0_rdata;
        w_c1_valid_next   = r_c1_valid;
        w_c1_rdata_next   = r_c1_rdata;

        case (r_state)
            StIdle: begin
                if (w_any_req) begin
                    w_grant_next      = w_pick;
                    w_last_grant_next = w_pick;
                    w_gray_addr_next  = w_pick ? c1_addr : c0_addr;
                    w_gray_req_next   = 1'b1;
                    w_state_next      = StIssue;
                end
            end
            StIssue: begin
                if (gray_ready) begin
                    w_gray_req_next = 1'b0;
                    w_state_next    = StCapt;
                end
            end
            StCapt: begin
                if (r_grant) begin
                    w_c1_rdata_next = gray_data;
                    w_c1_valid_next = 1'b1;
                end else begin
                    w_c0_rdata_next = gray_data;
                    w_c0_valid_next = 1'b1;
                end
                w_state_next = StResp;
            end
            StResp: begin
                w_c0_valid_next = 1'b0;
                w_c1_valid_next = 1'b0;
                w_state_next    = StIdle;
            end
            default: begin
                w_state_next = StIdle;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_grant      <= 1'b0;
            r_last_grant <= 1'b1;
            r_gray_req   <= 1'b0;
            r_gray_addr  <= '0;
            r_c0_valid   <= 1'b0;
            r_c0_rdata   <= '0;
            r_c1_valid   <= 1'b0;
            r_c1_rdata   <= '0;
        end else begin
            r_grant      <= w_grant_next;
            r_last_grant <= w_last_grant_next;
            r_gray_req   <= w_gray_req_next;
            r_gray_addr  <= w_gray_addr_next;
            r_c0_valid   <= w_c0_valid_next;
            r_c0_rdata   <= w_c0_rdata_next;
            r_c1_valid   <= w_c1_valid_next;
            r_c1_rdata   <= w_c1_rdata_next;
        end
    end

    // Sticky done flags clear on the finish edge; a done seen on that same
    // edge starts the next collection.
    assign w_both_done = r_d0 & r_d1;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_d0     <= 1'b0;
            r_d1     <= 1'b0;
            r_finish <= 1'b0;
        end else begin
            r_d0     <= (r_d0 & ~w_both_done) | c0_done;
            r_d1     <= (r_d1 & ~w_both_done) | c1_done;
            r_finish <= w_both_done;
        end
    end

    assign gray_req  = r_gray_req;
    assign gray_addr = r_gray_addr;
    assign c0_valid  = r_c0_valid;
    assign c0_rdata  = r_c0_rdata;
    assign c1_valid  = r_c1_valid;
    assign c1_rdata  = r_c1_rdata;
    assign finish    = r_finish;

endmodule

// File: tb/tb_gray_rd_arbiter.sv
// Directed bench for gray_rd_arbiter: per-cycle vector table for the read path,
// hand sequences for backpressure, late address change, mid-access reset and done merge.
module tb_gray_rd_arbiter;

    localparam int unsigned AW = 14;
    localparam int unsigned DW = 8;

    logic          clk;
    logic          reset;
    logic          c0_req, c1_req, c0_done, c1_done;
    logic [AW-1:0] c0_addr, c1_addr;
    logic          c0_valid, c1_valid;
    logic [DW-1:0] c0_rdata, c1_rdata;
    logic [AW-1:0] gray_addr;
    logic          gray_req, gray_ready;
    logic [DW-1:0] gray_data;
    logic          finish;

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;
    int fin_cnt  = 0;
    int fin_at   = -1;

    gray_rd_arbiter #(.AW(AW), .DW(DW)) dut (
        .clk        (clk),
        .reset      (reset),
        .c0_req     (c0_req),
        .c0_addr    (c0_addr),
        .c0_valid   (c0_valid),
        .c0_rdata   (c0_rdata),
        .c0_done    (c0_done),
        .c1_req     (c1_req),
        .c1_addr    (c1_addr),
        .c1_valid   (c1_valid),
        .c1_rdata   (c1_rdata),
        .c1_done    (c1_done),
        .gray_addr  (gray_addr),
        .gray_req   (gray_req),
        .gray_ready (gray_ready),
        .gray_data  (gray_data),
        .finish     (finish)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Memory image: mem[129]=5A, mem[130]=59, mem[200]=13, mem[258]=D8, mem[300]=F6.
    function automatic logic [7:0] mem_fn(input logic [13:0] a);
        return a[7:0] ^ 8'hDB ^ {2'b00, a[13:8]};
    endfunction

    // Data is presented only in the cycle after an acceptance edge; junk otherwise.
    initial begin
        logic          acc;
        logic [AW-1:0] a;
        gray_data = 8'hEE;
        forever begin
            @(negedge clk);
            acc = gray_req & gray_ready;
            a   = gray_addr;
            @(posedge clk);
            #1;
            gray_data = acc ? mem_fn(a) : 8'hEE;
        end
    end

    typedef struct {
        logic          c0_req;
        logic [AW-1:0] c0_addr;
        logic          c1_req;
        logic [AW-1:0] c1_addr;
        logic          ready;
        logic          rst;
        logic          e_req;
        logic [AW-1:0] e_addr;
        logic          e_v0;
        logic [DW-1:0] e_d0;
        logic          e_v1;
        logic [DW-1:0] e_d1;
    } vec_t;

    vec_t vecs[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        cyc++;
        if (finish === 1'b1) begin
            fin_cnt++;
            fin_at = cyc;
        end
    endtask

    task automatic pulse_reset();
        reset = 1'b1;
        @(posedge clk);
        #1;
        reset = 1'b0;
    endtask

    initial begin
        reset = 1'b1;
        c0_req = 1'b0; c1_req = 1'b0; c0_done = 1'b0; c1_done = 1'b0;
        c0_addr = '0; c1_addr = '0; gray_ready = 1'b1;
        #1;
        check("rst_gray_req", gray_req, 0);
        check("rst_gray_addr", gray_addr, 0);
        check("rst_c0_valid", c0_valid, 0);
        check("rst_c1_valid", c1_valid, 0);
        check("rst_c0_rdata", c0_rdata, 0);
        check("rst_c1_rdata", c1_rdata, 0);
        check("rst_finish", finish, 0);
        @(posedge clk);
        #1;
        reset = 1'b0;

        // Single client 0 access, addr 129 -> 5A.
        vecs.push_back('{1'b1, 14'd129, 1'b0, 14'd0, 1'b1, 1'b0, 1'b1, 14'd129, 1'b0, 8'h00, 1'b0, 8'h00});
        vecs.push_back('{1'b1, 14'd129, 1'b0, 14'd0, 1'b1, 1'b0, 1'b0, 14'd129, 1'b0, 8'h00, 1'b0, 8'h00});
        vecs.push_back('{1'b1, 14'd129, 1'b0, 14'd0, 1'b1, 1'b0, 1'b0, 14'd129, 1'b1, 8'h5A, 1'b0, 8'h00});
        vecs.push_back('{1'b1, 14'd129, 1'b0, 14'd0, 1'b1, 1'b0, 1'b0, 14'd129, 1'b0, 8'h5A, 1'b0, 8'h00});
        vecs.push_back('{1'b0, 14'd129, 1'b0, 14'd0, 1'b1, 1'b0, 1'b0, 14'd129, 1'b0, 8'h5A, 1'b0, 8'h00});
        // Tie from reset release: c0 (130->59), c1 (258->D8), c0, c1.
        vecs.push_back('{1'b1, 14'd130, 1'b1, 14'd258, 1'b1, 1'b1, 1'b1, 14'd130, 1'b0, 8'h00, 1'b0, 8'h00});
        vecs.push_back('{1'b1, 14'd130, 1'b1, 14'd258, 1'b1, 1'b0, 1'b0, 14'd130, 1'b0, 8'h00, 1'b0, 8'h00});
        vecs.push_back('{1'b1, 14'd130, 1'b1, 14'd258, 1'b1, 1'b0, 1'b0, 14'd130, 1'b1, 8'h59, 1'b0, 8'h00});
        vecs.push_back('{1'b1, 14'd130, 1'b1, 14'd258, 1'b1, 1'b0, 1'b0, 14'd130, 1'b0, 8'h59, 1'b0, 8'h00});
        vecs.push_back('{1'b1, 14'd130, 1'b1, 14'd258, 1'b1, 1'b0, 1'b1, 14'd258, 1'b0, 8'h59, 1'b0, 8'h00});
        vecs.push_back('{1'b1, 14'd130, 1'b1, 14'd258, 1'b1, 1'b0, 1'b0, 14'd258, 1'b0, 8'h59, 1'b0, 8'h00});
        vecs.push_back('{1'b1, 14'd130, 1'b1, 14'd258, 1'b1, 1'b0, 1'b0, 14'd258, 1'b0, 8'h59, 1'b1, 8'hD8});
        vecs.push_back('{1'b1, 14'd130, 1'b1, 14'd258, 1'b1, 1'b0, 1'b0, 14'd258, 1'b0, 8'h59, 1'b0, 8'hD8});
        vecs.push_back('{1'b1, 14'd130, 1'b1, 14'd258, 1'b1, 1'b0, 1'b1, 14'd130, 1'b0, 8'h59, 1'b0, 8'hD8});
        vecs.push_back('{1'b1, 14'd130, 1'b1, 14'd258, 1'b1, 1'b0, 1'b0, 14'd130, 1'b0, 8'h59, 1'b0, 8'hD8});
        vecs.push_back('{1'b1, 14'd130, 1'b1, 14'd258, 1'b1, 1'b0, 1'b0, 14'd130, 1'b1, 8'h59, 1'b0, 8'hD8});
        vecs.push_back('{1'b1, 14'd130, 1'b1, 14'd258, 1'b1, 1'b0, 1'b0, 14'd130, 1'b0, 8'h59, 1'b0, 8'hD8});
        vecs.push_back('{1'b1, 14'd130, 1'b1, 14'd258, 1'b1, 1'b0, 1'b1, 14'd258, 1'b0, 8'h59, 1'b0, 8'hD8});
        vecs.push_back('{1'b1, 14'd130, 1'b1, 14'd258, 1'b1, 1'b0, 1'b0, 14'd258, 1'b0, 8'h59, 1'b0, 8'hD8});
        vecs.push_back('{1'b1, 14'd130, 1'b1, 14'd258, 1'b1, 1'b0, 1'b0, 14'd258, 1'b0, 8'h59, 1'b1, 8'hD8});
        vecs.push_back('{1'b1, 14'd130, 1'b1, 14'd258, 1'b1, 1'b0, 1'b0, 14'd258, 1'b0, 8'h59, 1'b0, 8'hD8});

        for (int i = 0; i < vecs.size(); i++) begin
            c0_req = vecs[i].c0_req; c0_addr = vecs[i].c0_addr;
            c1_req = vecs[i].c1_req; c1_addr = vecs[i].c1_addr;
            gray_ready = vecs[i].ready;
            if (vecs[i].rst) pulse_reset();
            tick();
            check($sformatf("vec%0d_gray_req", i), gray_req, vecs[i].e_req);
            check($sformatf("vec%0d_gray_addr", i), gray_addr, vecs[i].e_addr);
            check($sformatf("vec%0d_c0_valid", i), c0_valid, vecs[i].e_v0);
            check($sformatf("vec%0d_c0_rdata", i), c0_rdata, vecs[i].e_d0);
            check($sformatf("vec%0d_c1_valid", i), c1_valid, vecs[i].e_v1);
            check($sformatf("vec%0d_c1_rdata", i), c1_rdata, vecs[i].e_d1);
        end

        // Backpressure: client 1 alone, six ISSUE cycles, ready only in the last.
        c0_req = 1'b0; c1_req = 1'b1; c1_addr = 14'd300; gray_ready = 1'b0;
        tick();
        for (int k = 1; k <= 6; k++) begin
            check($sformatf("bp_issue%0d_req", k), gray_req, 1);
            check($sformatf("bp_issue%0d_addr", k), gray_addr, 300);
            if (k == 6) gray_ready = 1'b1;
            tick();
        end
        check("bp_accept_req_low", gray_req, 0);
        check("bp_accept_no_valid", c1_valid, 0);
        tick();
        check("bp_c1_valid", c1_valid, 1);
        check("bp_c1_rdata", c1_rdata, 8'hF6);
        check("bp_c0_valid", c0_valid, 0);
        tick();
        check("bp_c1_valid_drop", c1_valid, 0);
        c1_req = 1'b0;

        // Address changes one cycle after the grant; the granted address stays.
        c0_req = 1'b1; c0_addr = 14'd200;
        tick();
        check("ach_grant_addr", gray_addr, 200);
        c0_addr = 14'd300;
        tick();
        check("ach_held_addr", gray_addr, 200);
        tick();
        check("ach_c0_valid", c0_valid, 1);
        check("ach_c0_rdata", c0_rdata, 8'h13);
        c0_req = 1'b0;
        tick();
        check("ach_c0_valid_drop", c0_valid, 0);

        // Reset in ISSUE; last grant was c0, so only a restored last_grant makes c0 win the tie.
        c0_req = 1'b1; c0_addr = 14'd130; gray_ready = 1'b0;
        tick();
        check("mrst_pre_req", gray_req, 1);
        reset = 1'b1;
        #1;
        check("mrst_gray_req", gray_req, 0);
        check("mrst_gray_addr", gray_addr, 0);
        check("mrst_c0_valid", c0_valid, 0);
        check("mrst_c1_valid", c1_valid, 0);
        check("mrst_c0_rdata", c0_rdata, 0);
        check("mrst_finish", finish, 0);
        c1_req = 1'b1; c1_addr = 14'd258; gray_ready = 1'b1;
        @(posedge clk);
        #1;
        reset = 1'b0;
        tick();
        check("mrst_tie_req", gray_req, 1);
        check("mrst_tie_addr", gray_addr, 130);
        tick();
        tick();
        check("mrst_c0_valid", c0_valid, 1);
        check("mrst_c0_rdata", c0_rdata, 8'h59);
        check("mrst_c1_quiet", c1_valid, 0);
        c0_req = 1'b0; c1_req = 1'b0;
        tick();

        // Done merge, cycle numbers relative to cyc=0.
        cyc = 0; fin_cnt = 0; fin_at = -1;
        while (cyc < 40) begin
            c0_done = (cyc == 10);
            c1_done = (cyc == 30);
            tick();
        end
        check("done_sep_count", fin_cnt, 1);
        check("done_sep_cycle", fin_at, 32);
        fin_cnt = 0; fin_at = -1;
        while (cyc < 60) begin
            c0_done = (cyc == 50);
            c1_done = (cyc == 50);
            tick();
        end
        check("done_same_count", fin_cnt, 1);
        check("done_same_cycle", fin_at, 52);
        fin_cnt = 0; fin_at = -1;
        while (cyc < 80) begin
            c0_done = (cyc == 62);
            c1_done = (cyc == 70);
            tick();
        end
        check("done_new_count", fin_cnt, 1);
        check("done_new_cycle", fin_at, 72);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
